// File: rtl/ui_cfg_pkg.sv
// Shared project constants for the UI configuration path.
// The display and timer blocks import these so their field widths match.
`timescale 1ns/1ps
package ui_cfg_pkg;

  localparam int PROG_W       = 3;
  localparam int MOD_W        = 2;
  localparam int DEB_CONT_DEF = 50;

endpackage

// File: rtl/ui_cfg_btn_deb.sv
// Per-button two-flop synchronizer and counting debouncer.
// rise is a registered one-cycle flag, set on the same edge that deb goes 0->1.
`timescale 1ns/1ps
module btn_deb #(
  parameter int DEB_CONT = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CONT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CONT - 1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values; with blocking, sync1->s would collapse to one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      rise  <= 1'b0;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb  <= s;
        cnt  <= '0;
        rise <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ui_cfg.sv
// UI configuration: two debounced buttons step the prog and modulo selectors.
// Outputs are registers; lock drops presses in the cycle they would apply.
`timescale 1ns/1ps
module ui_cfg
  import ui_cfg_pkg::*;
#(
  parameter int DEB_CONT = DEB_CONT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_prog,
  input  logic              btn_mod,
  input  logic              lock,
  output logic [PROG_W-1:0] prog,
  output logic [MOD_W-1:0]  modulo,
  output logic              cfg_upd
);

  logic prog_deb;
  logic prog_rise;
  logic mod_deb;
  logic mod_rise;
  logic prog_ev;
  logic mod_ev;

  btn_deb #(.DEB_CONT(DEB_CONT)) u_deb_prog (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_prog),
    .deb  (prog_deb),
    .rise (prog_rise)
  );

  btn_deb #(.DEB_CONT(DEB_CONT)) u_deb_mod (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_mod),
    .deb  (mod_deb),
    .rise (mod_rise)
  );

  // An event only counts while its accepted level is still high.
  assign prog_ev = prog_rise & prog_deb;
  assign mod_ev  = mod_rise & mod_deb;

  // Counters wrap naturally at their field width (7->0, 3->0).
  always_ff @(posedge clk) begin
    if (rst) begin
      prog    <= '0;
      modulo  <= '0;
      cfg_upd <= 1'b0;
    end else begin
      cfg_upd <= 1'b0;
      if (!lock) begin
        if (prog_ev) prog   <= prog + 1'b1;
        if (mod_ev)  modulo <= modulo + 1'b1;
        cfg_upd <= prog_ev | mod_ev;
      end
    end
  end

endmodule

// File: tb/tb_ui_cfg.sv
// Directed bench for ui_cfg with DEB_CONT=4: latency, glitch rejection, wrap,
// simultaneous presses, lock dropping and reset mid-debounce.
`timescale 1ns/1ps
module tb_ui_cfg;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_prog;
  logic       btn_mod;
  logic       lock;
  logic [2:0] prog;
  logic [1:0] modulo;
  logic       cfg_upd;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;
  int upd_base;
  int prog_exp;

  ui_cfg #(.DEB_CONT(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_prog (btn_prog),
    .btn_mod  (btn_mod),
    .lock     (lock),
    .prog     (prog),
    .modulo   (modulo),
    .cfg_upd  (cfg_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns later and pulses tallied.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cfg_upd === 1'b1) upd_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic p, input logic m, input int n_hi, input int n_lo);
    btn_prog = p;
    btn_mod  = m;
    tick(n_hi);
    btn_prog = 1'b0;
    btn_mod  = 1'b0;
    tick(n_lo);
  endtask

  initial begin
    rst = 1'b1; btn_prog = 1'b0; btn_mod = 1'b0; lock = 1'b0;
    tick(2);
    check("rst_prog", prog, 0);
    check("rst_mod", modulo, 0);
    check("rst_upd", cfg_upd, 0);
    rst = 1'b0;
    upd_cnt = 0;

    // Latency: raw high before edge 1, result exactly at edge 7.
    btn_prog = 1'b1;
    tick(6);
    check("lat_prog_e6", prog, 0);
    check("lat_upd_e6", cfg_upd, 0);
    tick(1);
    check("lat_prog_e7", prog, 1);
    check("lat_upd_e7", cfg_upd, 1);
    tick(1);
    check("lat_upd_e8", cfg_upd, 0);
    check("lat_mod", modulo, 0);
    tick(2);
    btn_prog = 1'b0;
    tick(10);
    check("lat_upd_cnt", upd_cnt, 1);

    // Glitch of 3 cycles is rejected.
    upd_base = upd_cnt;
    press(1'b0, 1'b1, 3, 12);
    check("glitch_mod", modulo, 0);
    check("glitch_upd", upd_cnt - upd_base, 0);

    // Eight presses walk prog through 1..7 and wrap to 0.
    do_reset();
    upd_base = upd_cnt;
    prog_exp = 0;
    for (int k = 0; k < 8; k++) begin
      press(1'b1, 1'b0, 10, 10);
      prog_exp = (prog_exp + 1) % 8;
      check($sformatf("wrap_prog_%0d", k), prog, prog_exp);
    end
    check("wrap_upd_cnt", upd_cnt - upd_base, 8);

    // Simultaneous presses: both change at edge 7 with one pulse.
    upd_base = upd_cnt;
    btn_prog = 1'b1;
    btn_mod  = 1'b1;
    tick(7);
    check("sim_prog", prog, 1);
    check("sim_mod", modulo, 1);
    check("sim_upd", cfg_upd, 1);
    tick(3);
    btn_prog = 1'b0;
    btn_mod  = 1'b0;
    tick(10);
    check("sim_upd_cnt", upd_cnt - upd_base, 1);

    // A long hold yields exactly one event.
    upd_base = upd_cnt;
    press(1'b0, 1'b1, 30, 10);
    check("hold_mod", modulo, 2);
    check("hold_upd_cnt", upd_cnt - upd_base, 1);

    // Lock drops a press; the next unlocked press is applied.
    do_reset();
    upd_base = upd_cnt;
    lock = 1'b1;
    press(1'b0, 1'b1, 10, 10);
    lock = 1'b0;
    check("lock_mod", modulo, 0);
    check("lock_upd_cnt", upd_cnt - upd_base, 0);
    press(1'b0, 1'b1, 10, 10);
    check("unlock_mod", modulo, 1);
    check("unlock_upd_cnt", upd_cnt - upd_base, 1);

    // Reset mid-debounce of a held button: one event 7 edges after rst falls.
    btn_prog = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_prog", prog, 0);
    check("mid_rst_mod", modulo, 0);
    upd_base = upd_cnt;
    tick(6);
    check("mid_prog_e6", prog, 0);
    tick(1);
    check("mid_prog_e7", prog, 1);
    check("mid_upd_e7", cfg_upd, 1);
    tick(10);
    btn_prog = 1'b0;
    tick(10);
    check("mid_upd_cnt", upd_cnt - upd_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ui_cfg.md
UI_CFG -- requirements
Module: ui_cfg

Interface
REQ-001 Parameter DEB_CONT, default 50, is the number of consecutive clk cycles a synchronized button level must hold before it is accepted.
REQ-002 The module SHALL have these ports, one per line, in this order:
  - clk  input  1  system clock, 100 MHz, single clock domain
  - rst  input  1  reset, synchronous, active-high
  - btn_prog  input  1  raw, asynchronous, bouncing push-button; each press advances prog
  - btn_mod  input  1  raw, asynchronous, bouncing push-button; each press advances modulo
  - lock  input  1  when high, accepted presses are discarded
  - prog  output  3  selected slow-clock frequency index, 0..7
  - modulo  output  2  selected data-source index, 0..3
  - cfg_upd  output  1  one-cycle pulse in the cycle prog or modulo takes a new value

Function
REQ-003 Each button SHALL pass through its own two-flop synchronizer; only the second-stage output (s) is used downstream.
REQ-004 Each button SHALL have an accepted level deb and a mismatch counter cnt of width clog2(DEB_CONT+1).
REQ-005 When s equals deb, cnt SHALL clear to 0.
REQ-006 When s differs from deb, cnt SHALL increment, subject to REQ-007.
REQ-007 When s differs from deb and cnt equals DEB_CONT-1, deb SHALL take s and cnt SHALL clear.
REQ-008 A press event SHALL be a 0->1 transition of deb; a 1->0 transition produces no event.
REQ-009 Press events SHALL be registered once, so prog/modulo update one cycle after deb rises.
REQ-010 Latency: with raw high from before edge 1 and held, the new prog/modulo value and cfg_upd appear at edge DEB_CONT+3.
REQ-011 A prog press with lock low SHALL set prog to prog+1 mod 8 (7 wraps to 0).
REQ-012 A modulo press with lock low SHALL set modulo to modulo+1 mod 4 (3 wraps to 0).
REQ-013 Press events occurring while lock is high (sampled in the update cycle) SHALL be dropped, not queued; prog, modulo and cfg_upd are unchanged.
REQ-014 Simultaneous prog and modulo events in the same cycle SHALL update both values, with a single one-cycle cfg_upd pulse.
REQ-015 A held button SHALL produce exactly one event; the next event requires deb to return to 0 (DEB_CONT stable low cycles) and rise again.
REQ-016 A pulse or glitch shorter than DEB_CONT synchronized cycles SHALL NOT change deb.
REQ-017 cfg_upd SHALL never be high for two consecutive cycles unless two distinct accepted events occur in consecutive cycles.
REQ-018 prog and modulo SHALL be driven directly from registers; no combinational path from any input to any output.

Reset
REQ-019 While rst is high at a clk edge: prog=0, modulo=0, cfg_upd=0, all synchronizer flops=0, deb=0, cnt=0, registered event flags=0.
REQ-020 Reset mid-debounce SHALL discard partial counts; a button held through rst deassertion yields one event DEB_CONT+3 edges after the first edge with rst low.

Structure
REQ-021 Constants PROG_W=3 and MOD_W=2, and the default DEB_CONT, SHALL live in the shared project package, so display and timer blocks use identical widths.
REQ-022 The synchronizer plus debounce per button SHALL be one sub-module, btn_deb (ports clk, rst, raw, deb, rise), instantiated twice; ui_cfg holds the counters, lock gating and cfg_upd.
REQ-023 prog and modulo SHALL connect unchanged to the display block's prog/modulo inputs.

Verification (DEB_CONT=4)
REQ-024 After rst, pulse btn_prog high for 10 cycles -> prog=1 and cfg_upd high exactly at edge 7; modulo stays 0.
REQ-025 Raise btn_mod high for 3 cycles, then low -> no change; cfg_upd never asserts.
REQ-026 Eight clean btn_prog presses, each followed by 10 cycles low -> prog goes 1,2,...,7,0; eight cfg_upd pulses.
REQ-027 btn_prog and btn_mod rise at the same edge -> prog=1, modulo=1 at the same edge, with one cfg_upd pulse.
REQ-028 lock=1 during a btn_mod press -> modulo unchanged and no cfg_upd; after lock=0, a new press sets modulo=1.
REQ-029 Assert rst for 1 cycle in the middle of the debounce of a held btn_prog -> outputs 0, then prog=1 at edge 7 after rst falls.
